// File: rtl/line_track_if.sv
// Sensor inputs and drive-command outputs of the line tracker.
// The master side drives the sensors, and the slave side is the tracker.
interface line_track_if;
    logic       left_signal;
    logic       mid_signal;
    logic       right_signal;
    logic [2:0] mode;
    logic       lost;
    logic       halted;

    modport master (output left_signal, mid_signal, right_signal,
                    input  mode, lost, halted);
    modport slave  (input  left_signal, mid_signal, right_signal,
                    output mode, lost, halted);
endinterface

// File: rtl/line_track_fsm.sv
// Line-following controller: synchronizes and debounces three line sensors,
// then tracks, searches for, or gives up on the line.
module line_track_fsm #(
    parameter int unsigned STABLE_CYC   = 1000,
    parameter int unsigned LOST_TIMEOUT = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    line_track_if.slave bus
);
    localparam logic [15:0] STAB     = 16'(STABLE_CYC);
    localparam logic [31:0] TMO_LAST = 32'(LOST_TIMEOUT - 1);

    localparam logic [2:0] M_LEFT   = 3'b000;
    localparam logic [2:0] M_RIGHT  = 3'b001;
    localparam logic [2:0] M_STR    = 3'b010;
    localparam logic [2:0] M_STOP   = 3'b011;
    localparam logic [2:0] M_SLEFT  = 3'b100;
    localparam logic [2:0] M_SRIGHT = 3'b101;

    typedef enum logic [1:0] {IDLE, TRACK, SEARCH, HALT} state_t;

    logic [2:0]  sync1, sync2, cand, pat;
    logic [15:0] cnt;
    logic        taken, acc;

    state_t      state_q, state_d;
    logic [2:0]  mode_q, mode_d;
    logic        lost_q, lost_d, halt_q, halt_d;
    logic        dir_q, dir_d;   // 0 = LEFT, 1 = RIGHT
    logic [31:0] tcnt_q, tcnt_d;
    logic        expire;

    // Sensor synchronizer and stability filter. A pattern that has held for
    // STABLE_CYC cycles is accepted once on the following edge, even if the
    // candidate is being reloaded on that same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            cand  <= '0;
            pat   <= '0;
            cnt   <= '0;
            taken <= 1'b0;
            acc   <= 1'b0;
        end else begin
            sync1 <= {bus.left_signal, bus.mid_signal, bus.right_signal};
            sync2 <= sync1;
            acc   <= 1'b0;
            if (cnt == STAB && !taken) begin
                pat   <= cand;
                acc   <= 1'b1;
                taken <= 1'b1;
            end
            if (sync2 != cand) begin
                cand  <= sync2;
                cnt   <= 16'd1;
                taken <= 1'b0;
            end else if (cnt < STAB) begin
                cnt <= cnt + 16'd1;
            end
        end
    end

    function automatic logic [2:0] map_pat(input logic [2:0] p, input logic [2:0] hold);
        case (p)
            3'b010, 3'b111: map_pat = M_STR;
            3'b110:         map_pat = M_LEFT;
            3'b011:         map_pat = M_RIGHT;
            3'b100:         map_pat = M_SLEFT;
            3'b001:         map_pat = M_SRIGHT;
            default:        map_pat = hold;
        endcase
    endfunction

    assign expire = (state_q == SEARCH) && (tcnt_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        tcnt_d  = tcnt_q;
        dir_d   = dir_q;
        case (state_q)
            IDLE, HALT: begin
                // A fork on first entry has no prior mode to hold: go straight.
                if (acc && pat != 3'b000) begin
                    state_d = TRACK;
                    mode_d  = map_pat(pat, M_STR);
                end
            end
            TRACK: begin
                if (acc) begin
                    if (pat == 3'b000) begin
                        state_d = SEARCH;
                        tcnt_d  = '0;
                        mode_d  = dir_q ? M_SRIGHT : M_SLEFT;
                    end else begin
                        mode_d = map_pat(pat, mode_q);
                    end
                end
            end
            SEARCH: begin
                tcnt_d = tcnt_q + 32'd1;
                // Regaining the line beats a simultaneous timeout.
                if (acc && pat != 3'b000) begin
                    state_d = TRACK;
                    mode_d  = map_pat(pat, M_STR);
                end else if (expire) begin
                    state_d = HALT;
                    mode_d  = M_STOP;
                end
            end
            default: state_d = IDLE;
        endcase
        if (mode_d == M_LEFT || mode_d == M_SLEFT)
            dir_d = 1'b0;
        else if (mode_d == M_RIGHT || mode_d == M_SRIGHT)
            dir_d = 1'b1;
        lost_d = (state_d == SEARCH);
        halt_d = (state_d == HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= M_STOP;
            lost_q  <= 1'b0;
            halt_q  <= 1'b0;
            dir_q   <= 1'b0;
            tcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            lost_q  <= lost_d;
            halt_q  <= halt_d;
            dir_q   <= dir_d;
            tcnt_q  <= tcnt_d;
        end
    end

    assign bus.mode   = mode_q;
    assign bus.lost   = lost_q;
    assign bus.halted = halt_q;
endmodule
